// File: rtl/grid_loader_axil_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grid_loader_axil_master_pkg
// Description : Shared constants, state encoding and write-kind tags for the
//               Game-of-Life grid loader AXI-Lite initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package grid_loader_axil_master_pkg;

    localparam int DATA_WIDTH             = 32;
    localparam int WORDS_PER_ROW          = 40;
    localparam int DEFAULT_NUM_ROWS       = 720;
    localparam int DEFAULT_COMMIT_REG_IDX = 41;
    localparam int DEFAULT_MODE_REG_IDX   = 40;

    localparam logic [1:0] AXI_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ROW = 2'd1,
        ST_ISSUE    = 2'd2,
        ST_WAIT_B   = 2'd3
    } state_t;

    // Which register class the current write targets.
    typedef enum logic [1:0] {
        WR_DATA   = 2'd0,
        WR_COMMIT = 2'd1,
        WR_MODE   = 2'd2
    } wr_kind_t;

endpackage

`default_nettype wire

// File: rtl/grid_loader_axil_master_axil_single_write.sv
`default_nettype none
// ============================================================================
// Module      : axil_single_write
// Description : Performs one AXI-Lite write (AW + W + B) per request, tracking
//               the AW and W valids independently.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_single_write
    import grid_loader_axil_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  issued_o,
    output logic                  ack_o,
    output logic [1:0]            resp_o,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [3:0]            wstrb_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o
);

    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  issued_q;
    logic                  ack_q;
    logic [1:0]            resp_q;

    logic w_idle;
    logic w_aw_pending_d;
    logic w_w_pending_d;

    assign w_idle         = !awvalid_q && !wvalid_q && !bready_q;
    assign w_aw_pending_d = awvalid_q && !awready_i;
    assign w_w_pending_d  = wvalid_q && !wready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            issued_q  <= 1'b0;
            ack_q     <= 1'b0;
            resp_q    <= AXI_OKAY;
        end else begin
            issued_q <= 1'b0;
            ack_q    <= 1'b0;
            if (req_i && w_idle) begin
                awaddr_q  <= addr_i;
                wdata_q   <= data_i;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
            end else if (awvalid_q || wvalid_q) begin
                // Each channel retires on its own handshake; B opens once both have.
                awvalid_q <= w_aw_pending_d;
                wvalid_q  <= w_w_pending_d;
                if (!w_aw_pending_d && !w_w_pending_d) begin
                    bready_q <= 1'b1;
                    issued_q <= 1'b1;
                end
            end else if (bready_q && bvalid_i) begin
                bready_q <= 1'b0;
                ack_q    <= 1'b1;
                resp_q   <= bresp_i;
            end
        end
    end

    assign awaddr_o  = awaddr_q;
    assign awvalid_o = awvalid_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = 4'hF;
    assign wvalid_o  = wvalid_q;
    assign bready_o  = bready_q;
    assign issued_o  = issued_q;
    assign ack_o     = ack_q;
    assign resp_o    = resp_q;

endmodule

`default_nettype wire

// File: rtl/grid_loader_axil_master.sv
`default_nettype none
// ============================================================================
// Module      : grid_loader_axil_master
// Description : Loads a full Game-of-Life grid into the pixel generator's
//               AXI-Lite register file row by row, then writes the run mode.
// Revision    : 1.0 - initial release
// ============================================================================
module grid_loader_axil_master
    import grid_loader_axil_master_pkg::*;
#(
    parameter int ROW_WIDTH           = WORDS_PER_ROW * DATA_WIDTH,
    parameter int NUM_ROWS            = DEFAULT_NUM_ROWS,
    parameter int AXI_LITE_ADDR_WIDTH = 8,
    parameter int COMMIT_REG_IDX      = DEFAULT_COMMIT_REG_IDX,
    parameter int MODE_REG_IDX        = DEFAULT_MODE_REG_IDX,
    localparam int ROW_IDX_WIDTH      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                           m_axi_lite_aclk,
    input  logic                           axi_reset,
    input  logic                           start,
    input  logic [DATA_WIDTH-1:0]          mode_value,
    input  logic [ROW_WIDTH-1:0]           row_data,
    input  logic                           row_valid,
    output logic                           row_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [ROW_IDX_WIDTH-1:0]       err_row,
    output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_awaddr,
    output logic                           m_axi_lite_awvalid,
    input  logic                           m_axi_lite_awready,
    output logic [DATA_WIDTH-1:0]          m_axi_lite_wdata,
    output logic [3:0]                     m_axi_lite_wstrb,
    output logic                           m_axi_lite_wvalid,
    input  logic                           m_axi_lite_wready,
    input  logic [1:0]                     m_axi_lite_bresp,
    input  logic                           m_axi_lite_bvalid,
    output logic                           m_axi_lite_bready
);

    localparam int WORDS      = ROW_WIDTH / DATA_WIDTH;
    localparam int WORD_WIDTH = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [AXI_LITE_ADDR_WIDTH-1:0] C_COMMIT_ADDR =
        AXI_LITE_ADDR_WIDTH'(COMMIT_REG_IDX * 4);
    localparam logic [AXI_LITE_ADDR_WIDTH-1:0] C_MODE_ADDR =
        AXI_LITE_ADDR_WIDTH'(MODE_REG_IDX * 4);
    localparam logic [ROW_IDX_WIDTH-1:0] C_LAST_ROW  = ROW_IDX_WIDTH'(NUM_ROWS - 1);
    localparam logic [WORD_WIDTH-1:0]    C_LAST_WORD = WORD_WIDTH'(WORDS - 1);

    state_t                     state_q;
    wr_kind_t                   kind_q;
    logic [ROW_IDX_WIDTH-1:0]   row_q;
    logic [WORD_WIDTH-1:0]      word_q;
    logic [ROW_WIDTH-1:0]       shreg_q;
    logic [DATA_WIDTH-1:0]      mode_q;
    logic                       req_q;
    logic                       row_ready_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       error_q;
    logic [ROW_IDX_WIDTH-1:0]   err_row_q;

    logic [AXI_LITE_ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]          w_data;
    logic                           w_issued;
    logic                           w_ack;
    logic [1:0]                     w_resp;

    // The leftmost unsent word always sits at the top of the shift register.
    always_comb begin
        w_addr = '0;
        w_data = '0;
        case (kind_q)
            WR_DATA: begin
                w_addr = AXI_LITE_ADDR_WIDTH'({word_q, 2'b00});
                w_data = shreg_q[ROW_WIDTH-1 -: DATA_WIDTH];
            end
            WR_COMMIT: begin
                w_addr = C_COMMIT_ADDR;
                w_data = DATA_WIDTH'(row_q);
            end
            WR_MODE: begin
                w_addr = C_MODE_ADDR;
                w_data = mode_q;
            end
            default: begin
                w_addr = '0;
                w_data = '0;
            end
        endcase
    end

    always_ff @(posedge m_axi_lite_aclk) begin
        if (axi_reset) begin
            state_q     <= ST_IDLE;
            kind_q      <= WR_DATA;
            row_q       <= '0;
            word_q      <= '0;
            shreg_q     <= '0;
            mode_q      <= '0;
            req_q       <= 1'b0;
            row_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_row_q   <= '0;
        end else begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_WAIT_ROW;
                        row_q       <= '0;
                        mode_q      <= mode_value;
                        error_q     <= 1'b0;
                        row_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_WAIT_ROW: begin
                    if (row_valid && row_ready_q) begin
                        shreg_q     <= row_data;
                        word_q      <= '0;
                        kind_q      <= WR_DATA;
                        req_q       <= 1'b1;
                        row_ready_q <= 1'b0;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_issued) begin
                        state_q <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (w_ack) begin
                        if (w_resp != AXI_OKAY) begin
                            error_q   <= 1'b1;
                            err_row_q <= row_q;
                            busy_q    <= 1'b0;
                            state_q   <= ST_IDLE;
                        end else begin
                            case (kind_q)
                                WR_DATA: begin
                                    req_q   <= 1'b1;
                                    state_q <= ST_ISSUE;
                                    if (word_q == C_LAST_WORD) begin
                                        kind_q <= WR_COMMIT;
                                    end else begin
                                        word_q  <= word_q + WORD_WIDTH'(1);
                                        shreg_q <= {shreg_q[ROW_WIDTH-DATA_WIDTH-1:0],
                                                    {DATA_WIDTH{1'b0}}};
                                    end
                                end
                                WR_COMMIT: begin
                                    if (row_q == C_LAST_ROW) begin
                                        kind_q  <= WR_MODE;
                                        req_q   <= 1'b1;
                                        state_q <= ST_ISSUE;
                                    end else begin
                                        row_q       <= row_q + ROW_IDX_WIDTH'(1);
                                        row_ready_q <= 1'b1;
                                        state_q     <= ST_WAIT_ROW;
                                    end
                                end
                                WR_MODE: begin
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                    state_q <= ST_IDLE;
                                end
                                default: begin
                                    busy_q  <= 1'b0;
                                    state_q <= ST_IDLE;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    axil_single_write #(
        .ADDR_WIDTH (AXI_LITE_ADDR_WIDTH)
    ) u_single_write (
        .clk       (m_axi_lite_aclk),
        .rst       (axi_reset),
        .req_i     (req_q),
        .addr_i    (w_addr),
        .data_i    (w_data),
        .issued_o  (w_issued),
        .ack_o     (w_ack),
        .resp_o    (w_resp),
        .awaddr_o  (m_axi_lite_awaddr),
        .awvalid_o (m_axi_lite_awvalid),
        .awready_i (m_axi_lite_awready),
        .wdata_o   (m_axi_lite_wdata),
        .wstrb_o   (m_axi_lite_wstrb),
        .wvalid_o  (m_axi_lite_wvalid),
        .wready_i  (m_axi_lite_wready),
        .bresp_i   (m_axi_lite_bresp),
        .bvalid_i  (m_axi_lite_bvalid),
        .bready_o  (m_axi_lite_bready)
    );

    assign row_ready = row_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_row   = err_row_q;

endmodule

`default_nettype wire

// File: tb/tb_grid_loader_axil_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_grid_loader_axil_master
// Description : Self-checking bench: 2-row frames against a write-sequence
//               model, with a configurable AXI-Lite responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_loader_axil_master;

    localparam int RW    = 1280;
    localparam int NR    = 2;
    localparam int WPR   = RW / 32;
    localparam int WPF   = NR * (WPR + 1) + 1;
    localparam int BOUND = 6000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [31:0]    mode_value = '0;
    logic [RW-1:0]  row_data = '0;
    logic           row_valid = 1'b0;
    logic           row_ready, busy, done, error;
    logic [0:0]     err_row;
    logic [7:0]     awaddr;
    logic           awvalid, wvalid, bready;
    logic           awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0]    wdata;
    logic [3:0]     wstrb;
    logic [1:0]     bresp = 2'b00;

    int checks = 0;
    int failures = 0;

    // responder configuration and observations
    int aw_delay = 0, w_delay = 0, b_delay = 0, err_at = -1;
    int aw_wait = 0, w_wait = 0, b_wait = 0;
    int aw_n = 0, w_n = 0, b_n = 0;
    int viol_strb = 0, viol_bready = 0;
    logic [7:0]  aw_log[$];
    logic [31:0] w_log[$];

    // frame model state
    logic [31:0] words [NR][WPR];
    logic [31:0] mode_v;
    int last_dones, rr_viol, aw_rr_viol;

    always #5 clk = ~clk;

    grid_loader_axil_master #(
        .ROW_WIDTH           (RW),
        .NUM_ROWS            (NR),
        .AXI_LITE_ADDR_WIDTH (8),
        .COMMIT_REG_IDX      (41),
        .MODE_REG_IDX        (40)
    ) dut (
        .m_axi_lite_aclk    (clk),
        .axi_reset          (rst),
        .start              (start),
        .mode_value         (mode_value),
        .row_data           (row_data),
        .row_valid          (row_valid),
        .row_ready          (row_ready),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .err_row            (err_row),
        .m_axi_lite_awaddr  (awaddr),
        .m_axi_lite_awvalid (awvalid),
        .m_axi_lite_awready (awready),
        .m_axi_lite_wdata   (wdata),
        .m_axi_lite_wstrb   (wstrb),
        .m_axi_lite_wvalid  (wvalid),
        .m_axi_lite_wready  (wready),
        .m_axi_lite_bresp   (bresp),
        .m_axi_lite_bvalid  (bvalid),
        .m_axi_lite_bready  (bready)
    );

    // Responder: decisions at the falling edge take effect at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
                aw_wait = 0; w_wait = 0; b_wait = 0;
                aw_n = 0; w_n = 0; b_n = 0;
                aw_log.delete(); w_log.delete();
            end else begin
                if (b_n < aw_n && b_n < w_n) begin
                    if (!bready) viol_bready++;
                    if (b_wait >= b_delay) begin
                        bvalid = 1'b1;
                        bresp  = (b_n == err_at) ? 2'b10 : 2'b00;
                        if (bready) begin
                            b_n++;
                            b_wait = 0;
                        end
                    end else begin
                        bvalid = 1'b0;
                        b_wait++;
                    end
                end else begin
                    bvalid = 1'b0;
                end
                if (awvalid && aw_wait >= aw_delay) begin
                    awready = 1'b1;
                    aw_log.push_back(awaddr);
                    aw_n++;
                    aw_wait = 0;
                end else begin
                    awready = 1'b0;
                    if (awvalid) aw_wait++;
                end
                if (wvalid && w_wait >= w_delay) begin
                    wready = 1'b1;
                    w_log.push_back(wdata);
                    if (wstrb !== 4'hF) viol_strb++;
                    w_n++;
                    w_wait = 0;
                end else begin
                    wready = 1'b0;
                    if (wvalid) w_wait++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] build_row(input int r);
        logic [RW-1:0] v;
        v = '0;
        for (int k = 0; k < WPR; k++) v = {v[RW-33:0], words[r][k]};
        return v;
    endfunction

    task automatic make_frame(input bit fixed);
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < WPR; k++)
                words[r][k] = fixed ? ((r == 0) ? 32'hAAAA_AAAA : 32'h5555_5555) : $urandom;
        mode_v = $urandom;
    endtask

    // Expected write i: 41 writes per row (40 data + commit), then one mode write.
    task automatic compare_log(input int base, input string tag);
        int r, k;
        logic [7:0]  ea;
        logic [31:0] ed;
        chk({tag, "_aw_count"}, aw_log.size() - base, WPF);
        chk({tag, "_w_count"},  w_log.size() - base,  WPF);
        for (int i = 0; i < WPF; i++) begin
            r = i / (WPR + 1);
            k = i % (WPR + 1);
            if (r == NR) begin
                ea = 8'hA0; ed = mode_v;
            end else if (k == WPR) begin
                ea = 8'hA4; ed = r;
            end else begin
                ea = 8'(4 * k); ed = words[r][k];
            end
            if (base + i < aw_log.size()) chk($sformatf("%s_addr%0d", tag, i), aw_log[base + i], ea);
            if (base + i < w_log.size())  chk($sformatf("%s_data%0d", tag, i), w_log[base + i], ed);
        end
    endtask

    task automatic run_frame(input int gap, input bit poke, input string tag);
        int r, gcnt, dones;
        bit rv_rr, prev_rr, finished;
        r = 0; gcnt = gap; dones = 0; rv_rr = 0; prev_rr = 0; finished = 0;
        @(negedge clk);
        mode_value = mode_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode_value = ~mode_v;
        chk({tag, "_busy_after_start"}, busy, 1'b1);
        chk({tag, "_error_cleared"}, error, 1'b0);
        for (int cyc = 0; cyc < BOUND && !finished; cyc++) begin
            @(negedge clk);
            if (done) dones++;
            if (rv_rr) begin
                r++;
                row_valid = 1'b0;
                gcnt = gap;
            end else if (prev_rr && !row_ready) begin
                rr_viol++;
            end
            if (row_ready && awvalid) aw_rr_viol++;
            if (!row_valid && r < NR) begin
                if (gcnt == 0) begin
                    row_valid = 1'b1;
                    row_data  = build_row(r);
                end else if (row_ready) begin
                    gcnt--;
                end
            end
            start = (poke && busy && (cyc % 37 == 5)) ? 1'b1 : 1'b0;
            prev_rr = row_ready;
            rv_rr   = row_valid && row_ready;
            if (!busy) finished = 1;
        end
        start = 1'b0;
        row_valid = 1'b0;
        chk({tag, "_finished"}, finished, 1'b1);
        last_dones = dones;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base;
        rr_viol = 0; aw_rr_viol = 0; last_dones = 0;

        // reset state
        do_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_row_ready", row_ready, 1'b0);
        chk("rst_valids", {awvalid, wvalid, bready, done}, 4'b0000);
        chk("rst_error", {error, err_row}, 2'b00);
        chk("rst_awaddr", awaddr, 8'h00);
        chk("rst_wdata", wdata, 32'h0);

        // alternating pattern, always ready
        make_frame(1'b1);
        run_frame(0, 1'b0, "pat");
        compare_log(0, "pat");
        chk("pat_done_pulses", last_dones, 1);
        chk("pat_busy_end", busy, 1'b0);

        // awready lags wready by 3 cycles
        make_frame(1'b0);
        aw_delay = 3; w_delay = 0; b_delay = 1;
        base = aw_log.size();
        run_frame(0, 1'b0, "awlag");
        compare_log(base, "awlag");
        chk("awlag_done_pulses", last_dones, 1);

        // wready lags awready by 5 cycles
        make_frame(1'b0);
        aw_delay = 0; w_delay = 5; b_delay = 0;
        base = aw_log.size();
        run_frame(0, 1'b0, "wlag");
        compare_log(base, "wlag");

        // both ready together after 5 cycles, slow B
        make_frame(1'b0);
        aw_delay = 5; w_delay = 5; b_delay = 4;
        base = aw_log.size();
        run_frame(0, 1'b0, "both");
        compare_log(base, "both");
        chk("both_done_pulses", last_dones, 1);

        // SLVERR on row 1, word 7
        aw_delay = 1; w_delay = 0; b_delay = 0;
        do_reset();
        make_frame(1'b0);
        err_at = (WPR + 1) + 7;
        run_frame(0, 1'b0, "err");
        chk("err_flag", error, 1'b1);
        chk("err_row", err_row, 1'b1);
        chk("err_busy", busy, 1'b0);
        chk("err_no_done", last_dones, 0);
        repeat (20) @(negedge clk);
        chk("err_no_more_aw", aw_log.size(), (WPR + 1) + 8);
        chk("err_sticky", error, 1'b1);
        err_at = -1;
        make_frame(1'b0);
        base = aw_log.size();
        run_frame(0, 1'b0, "err_restart");
        compare_log(base, "err_restart");
        chk("err_restart_error", error, 1'b0);

        // withheld rows and start pulses while busy
        make_frame(1'b0);
        aw_delay = 1; w_delay = 2; b_delay = 1;
        base = aw_log.size();
        run_frame(10, 1'b1, "gap");
        compare_log(base, "gap");
        chk("gap_done_pulses", last_dones, 1);

        // reset while awvalid is held
        make_frame(1'b0);
        aw_delay = 50; w_delay = 0; b_delay = 0;
        @(negedge clk);
        mode_value = mode_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        row_valid = 1'b1;
        row_data = build_row(0);
        for (int cyc = 0; cyc < 200 && !awvalid; cyc++) @(negedge clk);
        chk("mid_awvalid_seen", awvalid, 1'b1);
        row_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valids", {awvalid, wvalid, bready}, 3'b000);
        chk("mid_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        aw_delay = 0;
        @(negedge clk);
        make_frame(1'b0);
        run_frame(0, 1'b0, "after_rst");
        compare_log(0, "after_rst");

        chk("row_ready_dropped_early", rr_viol, 0);
        chk("aw_while_row_ready", aw_rr_viol, 0);
        chk("wstrb_not_full", viol_strb, 0);
        chk("bready_low_while_owed", viol_bready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
